mvm_exec_seq: RTL and testbench
===============================

# mvm_exec_seq

Parametrised exec-phase engine for the matrix-vector datapath. Once the load controller has filled the row FIFOs and the vector FIFO, this block drains them, accumulates `c[i] = sum_k a[i][k]*b[k]` for every row, and presents the results with a valid/ready handshake. It replaces hand-sequenced preload, enable and clear with an FSM that stalls on empty FIFOs, supports signed operands, and allows abort.

## Interface
- `N_ROWS`, 8: number of row FIFOs and MAC lanes.
- `K_LEN`, 8: elements per row and vector, 1..256.
- `DATA_WIDTH`, 8: operand width.
- `ACC_WIDTH`, 3*DATA_WIDTH: accumulator and result width.
- `SIGNED`, 0: 1 selects two's-complement operands with a sign-extended product.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins one pass; sampled only in IDLE.
- `abort`  in  1  synchronous; ends the pass and produces no result.
- `a_empty`  in  N_ROWS  row FIFO empty flags.
- `a_rdata`  in  N_ROWS x DATA_WIDTH  row FIFO outputs; registered, valid the cycle after the read.
- `a_rden`  out  N_ROWS  row FIFO read enables, all lanes identical.
- `b_empty`  in  1  vector FIFO empty flag.
- `b_rdata`  in  DATA_WIDTH  vector FIFO output; registered.
- `b_rden`  out  1  vector FIFO read enable.
- `busy`  out  1  high in any state other than IDLE.
- `res_valid`  out  1  high when `c_out` holds a completed pass.
- `res_ready`  in  1  consumer accepts the result.
- `c_out`  out  N_ROWS x ACC_WIDTH  accumulated results.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, HOLD.
- IDLE:
  - `start`=1 goes to CLEAR.
  - `abort` is ignored.
- CLEAR:
  - Zeroes all accumulators and `issue_cnt`.
  - Goes to RUN after one cycle.
- RUN:
  - `rd_go = ~|a_empty & ~b_empty & (issue_cnt < K_LEN)`.
  - `a_rden = {N_ROWS{rd_go}}` and `b_rden = rd_go`.
  - Each `rd_go` increments `issue_cnt`.
  - Any empty FIFO deasserts every read enable for that cycle (stall). No partial reads.
  - `mac_v` is a register loaded with `rd_go`.
  - When `mac_v`=1: `acc[i] += a_rdata[i]*b_rdata`.
  - The product is computed at 2*DATA_WIDTH, then extended (sign or zero per `SIGNED`) to ACC_WIDTH. The sum wraps modulo 2^ACC_WIDTH.
  - RUN goes to DRAIN in the cycle where `rd_go` is high and `issue_cnt == K_LEN-1`.
- DRAIN:
  - Performs the final accumulate (`mac_v`=1).
  - Goes to HOLD and sets `res_valid`.
- HOLD:
  - `c_out` equals the accumulators and is stable.
  - `res_valid & res_ready` clears `res_valid` and goes to IDLE.
  - `start` is ignored in HOLD.
- `abort` in CLEAR, RUN or DRAIN:
  - Goes to IDLE next edge and forces all read enables low in that cycle.
  - `mac_v` is cleared and `res_valid` stays 0.
  - FIFO contents already consumed are lost; this is the caller's responsibility.
- `abort` in HOLD: treated as `res_ready`.
- `c_out` keeps the last result until the next CLEAR zeroes it.

## Timing
- Reset values:
  - state IDLE; `busy`, `res_valid`, `a_rden`, `b_rden` all 0.
  - `c_out` 0, `issue_cnt` 0, `mac_v` 0.
- Reset while RUN: everything returns to the reset values immediately and no read enable glitches high.
- Read enables are combinational from the state, `issue_cnt` and the empty flags.
- Without stalls:
  - `start` sampled at edge E0.
  - Reads issue at E2..E(K_LEN+1).
  - Final accumulate at E(K_LEN+2); `res_valid` rises at that same edge.
- Each stall cycle adds exactly one cycle of latency.
- `res_valid` falls on the edge where `res_ready` is sampled high.
- With `res_ready` held high, back-to-back passes need one IDLE cycle between them.

## Structure
- `mvm_pkg` holds:
  - the state enum `mvm_state_t`;
  - `function clog2cnt(K_LEN)` for the `issue_cnt` width, which is $clog2(K_LEN+1);
  - localparam defaults shared with the load controller.
- Sub-module `mac_lane`:
  - Holds one accumulator with `en`, `clr`, `SIGNED`, DATA_WIDTH and ACC_WIDTH.
  - Instantiated N_ROWS times in a generate loop.
- The top level contains only the FSM, the counter and `mac_v`.

## Test plan
- Default parameters, unsigned: row i holds i+1 in every element and b = 1..8.
  - Expect `c_out[i] = 36*(i+1)`.
  - `res_valid` exactly 10 cycles after the start edge.
- Stall: hold `b_empty`=1 for 3 cycles after the 4th read.
  - No `a_rden` during the stall.
  - Same results; `res_valid` at 13 cycles.
- `SIGNED`=1: all a = 8'hFF (-1) and all b = 8'h02.
  - Expect every `c_out` = -16, i.e. 24'hFFFFF0.
- Overflow with `ACC_WIDTH`=16, unsigned: a = b = 255 with K_LEN=2.
  - Expect 130050 mod 65536 = 64514 (16'hFC02).
- Backpressure: hold `res_ready`=0 for 5 cycles and pulse `start` during HOLD.
  - `c_out` stable and `start` ignored.
  - IDLE the cycle after `res_ready`=1.
- Abort after 3 reads: `abort` for 1 cycle.
  - IDLE next cycle with `res_valid`=0.
  - Exactly 3 reads consumed.
- Reset mid-run: drop `rst_n` while in RUN.
  - All outputs go to 0 asynchronously and `busy`=0.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types and defaults for the matrix-vector exec engine and its load controller.
package mvm_pkg;

    localparam int MVM_N_ROWS     = 8;
    localparam int MVM_K_LEN      = 8;
    localparam int MVM_DATA_WIDTH = 8;
    localparam int MVM_ACC_WIDTH  = 3 * MVM_DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } mvm_state_t;

    // Counter width able to hold the value K_LEN itself (0..K_LEN).
    function automatic int clog2cnt(input int k_len);
        return $clog2(k_len + 1);
    endfunction

endpackage

// File: rtl/mvm_exec_seq_mac_lane.sv
// One multiply-accumulate lane: c += a*b with selectable operand signedness.
module mac_lane
    import mvm_pkg::*;
#(
    parameter int DATA_WIDTH = MVM_DATA_WIDTH,
    parameter int ACC_WIDTH  = MVM_ACC_WIDTH,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;
    logic signed [PW-1:0] prod;
    logic [ACC_WIDTH-1:0] prod_ext;

    // Widen operands to product width so one signed multiply serves both modes,
    // then sign- or zero-extend the product to the accumulator width.
    always_comb begin
        if (SIGNED != 0) begin
            a_x = PW'($signed(a));
            b_x = PW'($signed(b));
        end else begin
            a_x = PW'(a);
            b_x = PW'(b);
        end
        prod = a_x * b_x;
        if (SIGNED != 0) begin
            prod_ext = ACC_WIDTH'(prod);
        end else begin
            prod_ext = ACC_WIDTH'($unsigned(prod));
        end
    end

    // Accumulator: clear has priority, sum wraps at ACC_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/mvm_exec_seq.sv
// Exec-phase sequencer: drains row/vector FIFOs into N_ROWS MAC lanes and
// presents c = A*b with a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, abort ignored
// ST_CLEAR | zero accumulators and issue count
// ST_RUN   | issue column reads, stall while any FIFO is empty
// ST_DRAIN | final accumulate of the last column read
// ST_HOLD  | result valid on c_out until res_ready (or abort)
module mvm_exec_seq
    import mvm_pkg::*;
#(
    parameter int N_ROWS     = MVM_N_ROWS,
    parameter int K_LEN      = MVM_K_LEN,
    parameter int DATA_WIDTH = MVM_DATA_WIDTH,
    parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int SIGNED     = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [N_ROWS-1:0]                    a_empty,
    input  logic [N_ROWS-1:0][DATA_WIDTH-1:0]    a_rdata,
    output logic [N_ROWS-1:0]                    a_rden,
    input  logic                                 b_empty,
    input  logic [DATA_WIDTH-1:0]                b_rdata,
    output logic                                 b_rden,
    output logic                                 busy,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [N_ROWS-1:0][ACC_WIDTH-1:0]     c_out
);

    localparam int               CNT_W  = clog2cnt(K_LEN);
    localparam logic [CNT_W-1:0] K_END  = CNT_W'(K_LEN);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_LEN - 1);

    mvm_state_t       state;
    mvm_state_t       state_nxt;
    logic [CNT_W-1:0] issue_cnt;
    logic             mac_v;
    logic             rd_go;
    logic             clr_acc;

    // A column is read only when every FIFO can supply it; abort kills it in the same cycle.
    always_comb begin
        rd_go = (state == ST_RUN) && !abort && !(|a_empty) && !b_empty && (issue_cnt < K_END);
    end

    assign a_rden    = {N_ROWS{rd_go}};
    assign b_rden    = rd_go;
    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_HOLD);
    assign clr_acc   = (state == ST_CLEAR);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (rd_go && (issue_cnt == K_LAST)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = abort ? ST_IDLE : ST_HOLD;
            ST_HOLD:  if (res_ready || abort) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, issue counter and the one-cycle read-to-accumulate pipeline flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            issue_cnt <= '0;
            mac_v     <= 1'b0;
        end else begin
            state <= state_nxt;
            mac_v <= rd_go;
            if (clr_acc) begin
                issue_cnt <= '0;
            end else if (rd_go) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_ROWS; i++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SIGNED     (SIGNED)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_acc),
            .en    (mac_v),
            .a     (a_rdata[i]),
            .b     (b_rdata),
            .acc   (c_out[i])
        );
    end

endmodule

// File: tb/tb_mvm_exec_seq.sv
// Bench for mvm_exec_seq: queue-based FIFO model, arithmetic result model,
// per-cycle compare process and directed timing/boundary checks.
module tb_mvm_exec_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance: defaults, fed by the FIFO model
    logic             start = 1'b0, abort = 1'b0, res_ready = 1'b1;
    logic [7:0]       a_empty = '1;
    logic             b_empty = 1'b1;
    logic [7:0][7:0]  a_rdata = '0;
    logic [7:0]       b_rdata = '0;
    logic [7:0]       a_rden;
    logic             b_rden, busy, res_valid;
    logic [7:0][23:0] c_out;

    // signed instance: constant always-ready FIFOs, a = -1, b = 2
    logic             s_start = 1'b0, s_abort = 1'b0, s_res_ready = 1'b1;
    logic [7:0]       s_a_empty = '0;
    logic             s_b_empty = 1'b0;
    logic [7:0][7:0]  s_a_rdata = {8{8'hFF}};
    logic [7:0]       s_b_rdata = 8'h02;
    logic [7:0]       s_a_rden;
    logic             s_b_rden, s_busy, s_res_valid;
    logic [7:0][23:0] s_c_out;

    // overflow instance: 2 rows, K_LEN 2, 16-bit accumulator, a = b = 255
    logic             o_start = 1'b0, o_abort = 1'b0, o_res_ready = 1'b1;
    logic [1:0]       o_a_empty = '0;
    logic             o_b_empty = 1'b0;
    logic [1:0][7:0]  o_a_rdata = {2{8'hFF}};
    logic [7:0]       o_b_rdata = 8'hFF;
    logic [1:0]       o_a_rden;
    logic             o_b_rden, o_busy, o_res_valid;
    logic [1:0][15:0] o_c_out;

    mvm_exec_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_empty(a_empty), .a_rdata(a_rdata), .a_rden(a_rden),
        .b_empty(b_empty), .b_rdata(b_rdata), .b_rden(b_rden),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .c_out(c_out)
    );

    mvm_exec_seq #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .a_empty(s_a_empty), .a_rdata(s_a_rdata), .a_rden(s_a_rden),
        .b_empty(s_b_empty), .b_rdata(s_b_rdata), .b_rden(s_b_rden),
        .busy(s_busy), .res_valid(s_res_valid), .res_ready(s_res_ready), .c_out(s_c_out)
    );

    mvm_exec_seq #(.N_ROWS(2), .K_LEN(2), .ACC_WIDTH(16)) u_ovf (
        .clk(clk), .rst_n(rst_n), .start(o_start), .abort(o_abort),
        .a_empty(o_a_empty), .a_rdata(o_a_rdata), .a_rden(o_a_rden),
        .b_empty(o_b_empty), .b_rdata(o_b_rdata), .b_rden(o_b_rden),
        .busy(o_busy), .res_valid(o_res_valid), .res_ready(o_res_ready), .c_out(o_c_out)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Registered FIFO model: data appears the cycle after a read; optional b stall.
    logic [7:0] aq[8][$];
    logic [7:0] bq[$];
    int rd_count   = 0;
    int stall_left = 0;
    bit stall_en   = 1'b0;

    always @(posedge clk) begin
        if (stall_left > 0) stall_left--;
        for (int i = 0; i < 8; i++) begin
            if (a_rden[i] && aq[i].size() > 0) a_rdata[i] <= aq[i].pop_front();
        end
        if (b_rden && bq.size() > 0) begin
            b_rdata <= bq.pop_front();
            rd_count++;
            if (stall_en && rd_count % 8 == 4) stall_left = 3;
        end
        for (int i = 0; i < 8; i++) a_empty[i] <= (aq[i].size() == 0);
        b_empty <= (bq.size() == 0) || (stall_left > 0);
    end

    // Result model: plain dot products, wrapped to the accumulator width.
    longint exp_c[8];
    longint exp_s;
    longint exp_o;

    function automatic int sx8(input logic [7:0] v);
        return (v >= 8'd128) ? int'(v) - 256 : int'(v);
    endfunction

    task automatic load_main(input int mode);
        logic [7:0] av;
        logic [7:0] bv;
        for (int i = 0; i < 8; i++) exp_c[i] = 0;
        for (int k = 0; k < 8; k++) begin
            bv = (mode == 0) ? 8'(k + 1) : 8'((k * 53 + 129) % 256);
            bq.push_back(bv);
            for (int i = 0; i < 8; i++) begin
                av = (mode == 0) ? 8'(i + 1) : 8'((i * 37 + k * 11 + 200) % 256);
                aq[i].push_back(av);
                exp_c[i] += longint'(av) * longint'(bv);
            end
        end
        for (int i = 0; i < 8; i++) exp_c[i] = exp_c[i] & 64'hFF_FFFF;
    endtask

    task automatic flush();
        for (int i = 0; i < 8; i++) aq[i].delete();
        bq.delete();
    endtask

    function automatic logic rv_of(input int sel);
        return (sel == 0) ? res_valid : (sel == 1) ? s_res_valid : o_res_valid;
    endfunction

    // Called at a negedge; returns at the negedge just after the sampling edge.
    task automatic pulse_start(input int sel);
        case (sel)
            0:       start   = 1'b1;
            1:       s_start = 1'b1;
            default: o_start = 1'b1;
        endcase
        @(negedge clk);
        start   = 1'b0;
        s_start = 1'b0;
        o_start = 1'b0;
    endtask

    // Cycles from the start edge until res_valid is seen; -1 on timeout.
    task automatic wait_rv(input int sel, output int lat);
        int t0;
        t0  = cyc;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (rv_of(sel)) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Per-cycle compare against the model and the read-enable rules.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rden_lanes_equal", longint'(a_rden), longint'({8{b_rden}}));
            if (b_rden) chk("rden_while_empty", longint'({a_empty, b_empty}), 0);
            if (res_valid) begin
                for (int i = 0; i < 8; i++) chk("c_out_model", longint'(c_out[i]), exp_c[i]);
            end
            if (s_res_valid) begin
                for (int i = 0; i < 8; i++) chk("sgn_c_out_model", longint'(s_c_out[i]), exp_s);
            end
            if (o_res_valid) begin
                for (int i = 0; i < 2; i++) chk("ovf_c_out_model", longint'(o_c_out[i]), exp_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;

        exp_s = 0;
        for (int k = 0; k < 8; k++) exp_s += longint'(sx8(8'hFF) * sx8(8'h02));
        exp_s = exp_s & 64'hFF_FFFF;
        exp_o = 0;
        for (int k = 0; k < 2; k++) exp_o += 255 * 255;
        exp_o = exp_o & 64'hFFFF;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_a_rden", longint'(a_rden), 0);
        chk("rst_b_rden", b_rden, 0);
        chk("rst_c_out_zero", |c_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // unsigned pass, no stalls
        base = rd_count;
        load_main(0);
        repeat (2) @(negedge clk);
        pulse_start(0);
        wait_rv(0, lat);
        chk("t1_latency", lat, 10);
        chk("t1_c0_literal", longint'(c_out[0]), 36);
        chk("t1_c7_literal", longint'(c_out[7]), 288);
        @(negedge clk);
        chk("t1_idle_after_ready", busy, 0);
        chk("t1_reads", rd_count - base, 8);

        // three-cycle b stall after the 4th read
        stall_en = 1'b1;
        base = rd_count;
        load_main(0);
        repeat (2) @(negedge clk);
        pulse_start(0);
        wait_rv(0, lat);
        chk("t2_stall_latency", lat, 13);
        chk("t2_c3_literal", longint'(c_out[3]), 144);
        chk("t2_reads", rd_count - base, 8);
        stall_en = 1'b0;
        @(negedge clk);

        // backpressure, start ignored in HOLD
        res_ready = 1'b0;
        load_main(1);
        repeat (2) @(negedge clk);
        pulse_start(0);
        wait_rv(0, lat);
        chk("t3_latency", lat, 10);
        chk("t3_c0_literal", longint'(c_out[0]), 186792);
        for (int n = 0; n < 5; n++) begin
            start = (n == 2);
            @(negedge clk);
            chk("t3_hold_valid", res_valid, 1);
            chk("t3_hold_busy", busy, 1);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("t3_idle_valid", res_valid, 0);
        chk("t3_idle_busy", busy, 0);
        @(negedge clk);
        chk("t3_start_not_latched", busy, 0);
        for (int i = 0; i < 8; i++) chk("t3_c_out_kept", longint'(c_out[i]), exp_c[i]);

        // abort after 3 reads
        base = rd_count;
        load_main(0);
        repeat (2) @(negedge clk);
        pulse_start(0);
        for (int n = 0; n < 20 && (rd_count - base) < 3; n++) @(negedge clk);
        chk("t4_rden_before_abort", b_rden, 1);
        abort = 1'b1;
        #1;
        chk("t4_abort_b_rden", b_rden, 0);
        chk("t4_abort_a_rden", longint'(a_rden), 0);
        @(negedge clk);
        abort = 1'b0;
        chk("t4_idle", busy, 0);
        chk("t4_no_valid", res_valid, 0);
        repeat (3) @(negedge clk);
        chk("t4_reads", rd_count - base, 3);
        chk("t4_still_idle", busy, 0);
        flush();

        // asynchronous reset mid-run
        base = rd_count;
        load_main(0);
        repeat (2) @(negedge clk);
        pulse_start(0);
        for (int n = 0; n < 20 && (rd_count - base) < 2; n++) @(negedge clk);
        chk("t5_running", busy, 1);
        chk("t5_partial_c0", longint'(c_out[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", res_valid, 0);
        chk("t5_rst_a_rden", longint'(a_rden), 0);
        chk("t5_rst_b_rden", b_rden, 0);
        chk("t5_rst_c_out_zero", |c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        flush();
        @(negedge clk);

        // signed operands
        pulse_start(1);
        wait_rv(1, lat);
        chk("sgn_latency", lat, 10);
        for (int i = 0; i < 8; i++) chk("sgn_literal", longint'(s_c_out[i]), 24'hFFFFF0);
        @(negedge clk);

        // accumulator wrap with K_LEN = 2
        pulse_start(2);
        wait_rv(2, lat);
        chk("ovf_latency", lat, 4);
        chk("ovf_literal", longint'(o_c_out[0]), 16'hFC02);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
